// File: rtl/multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Moore-style control sequencer for a multi-cycle RV32I datapath that shares
// one memory port between instruction fetch and data access. Each instruction
// moves through fetch, decode, execute, memory and writeback. Supported
// opcodes are R-type, I-immediate, load, store and branch. Any other opcode is
// reported as illegal and skipped.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset; forces every output to 0
//   opcode[6:0]    instruction register opcode field
//   mem_ready      memory port accepted/completed the current request
//   stall          freezes the non-memory states
//   mem_req        memory request
//   mem_we         1 = write, 0 = read (valid while mem_req is high)
//   ir_write       load the instruction register
//   pc_write       unconditional PC update (PC + 4)
//   pc_write_cond  PC update if the branch condition holds
//   reg_write      register file write enable
//   mem_to_reg     writeback source: 1 = memory data, 0 = ALU result
//   alu_src_a[1:0] ALU A select: 00 = PC, 01 = rs1
//   alu_src_b[1:0] ALU B select: 00 = rs2, 01 = 4, 10 = immediate
//   alu_op[1:0]    00 add, 01 branch compare, 10 R-type decode, 11 I-type decode
//   imm_sel[2:0]   immediate format: 000 = I, 001 = S, 010 = B
//   instr_retired  one-cycle pulse when an instruction completes
//   illegal_instr  one-cycle pulse for an unsupported opcode
//   bus_error      memory timeout occurred (held until reset)
//   state[3:0]     current state encoding, for debug
// ----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_sel,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // A zero timeout disables the check; keep the counter at least one bit wide.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_MAX = CW'(MEM_TIMEOUT);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   tmo_cnt;
  logic            in_mem;
  logic            timed_out;

  assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
  // A same-cycle mem_ready always wins over the timeout.
  assign timed_out = in_mem && !mem_ready && (MEM_TIMEOUT != 0) &&
                     (tmo_cnt == TMO_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Any state change clears the count, which covers entry into a memory
      // state; it then only counts consecutive unanswered request cycles.
      if (!in_mem || mem_ready || (state_d != state_q)) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    imm_sel       = 3'b000;
    instr_retired = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    state         = 4'd0;

    // Outputs are gated by reset directly so nothing fires in a reset cycle,
    // even before the state register has returned to FETCH.
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      state = state_q;
      unique case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (timed_out) begin
            state_d = S_ERROR;
          end
        end
        S_DECODE: begin
          // Branch target PC + B-immediate is precomputed here.
          alu_src_b = 2'b10;
          imm_sel   = 3'b010;
          if (!stall) begin
            case (opcode)
              OP_R:               state_d = S_EXEC_R;
              OP_I:               state_d = S_EXEC_I;
              OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
              OP_BRANCH:          state_d = S_BRANCH;
              default:            state_d = S_ILLEGAL;
            endcase
          end
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          imm_sel   = (opcode == OP_STORE) ? 3'b001 : 3'b000;
          if (!stall) begin
            state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          if (mem_ready)      state_d = S_MEM_WB;
          else if (timed_out) state_d = S_ERROR;
        end
        S_MEM_WB: begin
          mem_to_reg = 1'b1;
          if (!stall) begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
          end
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (mem_ready) begin
            instr_retired = 1'b1;
            state_d       = S_FETCH;
          end else if (timed_out) begin
            state_d = S_ERROR;
          end
        end
        S_EXEC_R: begin
          alu_src_a = 2'b01;
          alu_op    = 2'b10;
          if (!stall) state_d = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
          if (!stall) state_d = S_ALU_WB;
        end
        S_ALU_WB: begin
          if (!stall) begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
          end
        end
        S_BRANCH: begin
          alu_src_a = 2'b01;
          alu_op    = 2'b01;
          if (!stall) begin
            pc_write_cond = 1'b1;
            instr_retired = 1'b1;
            state_d       = S_FETCH;
          end
        end
        S_ILLEGAL: begin
          // PC already advanced in FETCH, so returning there skips the word.
          if (!stall) begin
            illegal_instr = 1'b1;
            state_d       = S_FETCH;
          end
        end
        S_ERROR: begin
          bus_error = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed stimulus for multicycle_control_fsm (MEM_TIMEOUT = 4). Each driven
// cycle pushes its hand-derived expected output vector into a scoreboard
// queue; an independent monitor pops one entry per falling clock edge and
// compares it against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_sel;
    logic       retired;
    logic       illegal;
    logic       bus_error;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = OP_R;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;

  logic       mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write;
  logic       mem_to_reg, instr_retired, illegal_instr, bus_error;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_sel;
  logic [3:0] state;

  item_t sb[$];
  int    passed = 0;
  int    total  = 0;
  out_t  act;

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .instr_retired(instr_retired),
    .illegal_instr(illegal_instr),
    .bus_error    (bus_error),
    .state        (state)
  );

  always #5 clk = ~clk;

  assign act = {state, mem_req, mem_we, ir_write, pc_write, pc_write_cond,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_sel,
                instr_retired, illegal_instr, bus_error};

  // Expected outputs for one cycle, written out per state from the state
  // table: st is the state the bench expects the DUT to be in.
  function automatic out_t exp_for(input logic [3:0] st, input logic [6:0] op,
                                   input logic rdy, input logic stl);
    out_t e;
    e    = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.mem_req = 1'b1; e.src_b = 2'b01;
                   e.ir_write = rdy; e.pc_write = rdy; end
      4'd1:  begin e.src_b = 2'b10; e.imm_sel = 3'b010; end
      4'd2:  begin e.src_a = 2'b01; e.src_b = 2'b10;
                   e.imm_sel = (op == OP_ST) ? 3'b001 : 3'b000; end
      4'd3:  begin e.mem_req = 1'b1; end
      4'd4:  begin e.mem_to_reg = 1'b1; e.reg_write = !stl; e.retired = !stl; end
      4'd5:  begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.retired = rdy; end
      4'd6:  begin e.src_a = 2'b01; e.alu_op = 2'b10; end
      4'd7:  begin e.src_a = 2'b01; e.src_b = 2'b10; e.alu_op = 2'b11; end
      4'd8:  begin e.reg_write = !stl; e.retired = !stl; end
      4'd9:  begin e.src_a = 2'b01; e.alu_op = 2'b01;
                   e.pc_write_cond = !stl; e.retired = !stl; end
      4'd10: begin e.illegal = !stl; end
      4'd11: begin e.bus_error = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  // One stimulus cycle: drive inputs just after the rising edge and queue the
  // outputs expected for that cycle (all zero while reset is high).
  task automatic cyc(input logic rst, input logic [6:0] op, input logic rdy,
                     input logic stl, input logic [3:0] st, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    stall     = stl;
    it.v      = rst ? out_t'('0) : exp_for(st, op, rdy, stl);
    it.tag    = tag;
    sb.push_back(it);
  endtask

  // Monitor: one comparison per queued cycle, sampled on the falling edge.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (act === e.v) begin
          passed++;
        end else begin
          $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                   e.tag, act, act.st, e.v, e.v.st);
        end
      end
    end
  end

  initial begin
    // Reset held two cycles, then R-type: 0,1,6,8.
    cyc(1, OP_R, 1, 0, 0, "rst_a");
    cyc(1, OP_R, 1, 0, 0, "rst_b");
    cyc(0, OP_R, 1, 0, 0, "r_fetch");
    cyc(0, OP_R, 1, 0, 1, "r_decode");
    cyc(0, OP_R, 1, 0, 6, "r_exec");
    cyc(0, OP_R, 1, 0, 8, "r_wb");

    // Load with three wait cycles in MEM_RD: 8 cycles total.
    cyc(0, OP_LD, 1, 0, 0, "ld_fetch");
    cyc(0, OP_LD, 1, 0, 1, "ld_decode");
    cyc(0, OP_LD, 1, 0, 2, "ld_addr");
    for (int i = 0; i < 3; i++) cyc(0, OP_LD, 0, 0, 3, "ld_rd_wait");
    cyc(0, OP_LD, 1, 0, 3, "ld_rd_done");
    cyc(0, OP_LD, 1, 0, 4, "ld_wb");

    // Store with zero wait: 4 cycles.
    cyc(0, OP_ST, 1, 0, 0, "st_fetch");
    cyc(0, OP_ST, 1, 0, 1, "st_decode");
    cyc(0, OP_ST, 1, 0, 2, "st_addr");
    cyc(0, OP_ST, 1, 0, 5, "st_wr");

    // Unsupported opcode.
    cyc(0, OP_BAD, 1, 0, 0, "ill_fetch");
    cyc(0, OP_BAD, 1, 0, 1, "ill_decode");
    cyc(0, OP_BAD, 1, 0, 10, "ill_pulse");

    // Branch stalled for two cycles on entry.
    cyc(0, OP_BR, 1, 0, 0, "br_fetch");
    cyc(0, OP_BR, 1, 0, 1, "br_decode");
    cyc(0, OP_BR, 1, 1, 9, "br_stall_a");
    cyc(0, OP_BR, 1, 1, 9, "br_stall_b");
    cyc(0, OP_BR, 1, 0, 9, "br_go");

    // I-type with stall ignored in FETCH, honoured in DECODE/EXEC_I/ALU_WB.
    cyc(0, OP_I, 1, 1, 0, "i_fetch_stall");
    cyc(0, OP_I, 1, 1, 1, "i_decode_stall");
    cyc(0, OP_I, 1, 0, 1, "i_decode");
    cyc(0, OP_I, 1, 1, 7, "i_exec_stall");
    cyc(0, OP_I, 1, 0, 7, "i_exec");
    cyc(0, OP_I, 1, 1, 8, "i_wb_stall");
    cyc(0, OP_I, 1, 0, 8, "i_wb");

    // Ready arriving on the last allowed wait cycle beats the timeout.
    for (int i = 0; i < 4; i++) cyc(0, OP_BAD, 0, 0, 0, "tmo_edge_wait");
    cyc(0, OP_BAD, 1, 0, 0, "tmo_edge_ready");
    cyc(0, OP_BAD, 1, 0, 1, "tmo_edge_decode");
    cyc(0, OP_BAD, 1, 0, 10, "tmo_edge_ill");

    // Reset in the middle of a load handshake aborts to FETCH.
    cyc(0, OP_LD, 1, 0, 0, "ab_fetch");
    cyc(0, OP_LD, 1, 0, 1, "ab_decode");
    cyc(0, OP_LD, 1, 0, 2, "ab_addr");
    cyc(0, OP_LD, 0, 0, 3, "ab_rd_wait");
    cyc(1, OP_LD, 0, 0, 0, "ab_reset");

    // Fetch timeout: five unanswered FETCH cycles, then ERROR until reset.
    for (int i = 0; i < 5; i++) cyc(0, OP_R, 0, 0, 0, "to_fetch_wait");
    for (int i = 0; i < 20; i++) cyc(0, OP_R, 1, 1, 11, "to_error");
    cyc(1, OP_R, 1, 0, 0, "to_reset");
    cyc(0, OP_R, 1, 0, 0, "to_fetch_after");
    cyc(0, OP_R, 1, 0, 1, "to_decode_after");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0 pending", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
